// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: reverse-Polish command engine sitting in front of a LIFO.
// Takes one command per handshake, pops operands, computes and pushes the
// result back through the stack's rd/wr port. Flags overflow, underflow and
// illegal opcodes on a one-cycle err pulse with a sticky err_code.
// Build option: define RPN_MUL_EN to enable op 111 as MUL; otherwise it is illegal.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a command
// POP_A   | pop top operand A (DROP: pop and discard)
// POP_B   | pop second operand Bv; on underflow restore A then flag
// EXEC    | R = Bv op A, modulo 2**B
// PUSH    | push latched value (command data, result, dup or restore)
// DUP_RD  | read top without popping
// ERR     | one-cycle err pulse, then IDLE

module rpn_stack_engine #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [B-1:0] cmd_data,
  output logic         stk_rd,
  output logic         stk_wr,
  output logic [B-1:0] stk_w_data,
  input  logic [B-1:0] stk_r_data,
  input  logic         stk_empty,
  input  logic         stk_full,
  output logic [B-1:0] res_data,
  output logic         res_valid,
  output logic         err,
  output logic [1:0]   err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP_A, S_POP_B, S_EXEC, S_PUSH, S_DUP_RD, S_ERR
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_DROP = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] CODE_OVF = 2'b01;
  localparam logic [1:0] CODE_UNF = 2'b10;
  localparam logic [1:0] CODE_ILL = 2'b11;

  state_t       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [B-1:0] a_q, a_d;
  logic [B-1:0] b_q, b_d;
  logic [B-1:0] val_q, val_d;
  logic [B-1:0] res_q, res_d;
  logic [1:0]   code_q, code_d;
  logic         restore_q, restore_d;

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      val_q     <= '0;
      res_q     <= '0;
      code_q    <= '0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      val_q     <= val_d;
      res_q     <= res_d;
      code_q    <= code_d;
      restore_q <= restore_d;
    end
  end

  // Next-state, datapath updates and stack strobes. Strobes decode the
  // registered state, qualified by the stack flags seen in that same cycle,
  // so a pop and its empty check always refer to the same stack snapshot.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    val_d     = val_q;
    res_d     = res_q;
    code_d    = code_q;
    restore_d = restore_q;
    stk_rd    = 1'b0;
    stk_wr    = 1'b0;
    cmd_ready = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          restore_d = 1'b0;
          case (cmd_op)
            OP_PUSH: begin
              val_d   = cmd_data;
              state_d = S_PUSH;
            end
            OP_DUP:  state_d = S_DUP_RD;
`ifdef RPN_MUL_EN
            OP_MUL:  state_d = S_POP_A;
`else
            OP_MUL: begin
              code_d  = CODE_ILL;
              state_d = S_ERR;
            end
`endif
            default: state_d = S_POP_A;
          endcase
        end
      end

      S_POP_A: begin
        if (stk_empty) begin
          code_d  = CODE_UNF;
          state_d = S_ERR;
        end else begin
          stk_rd  = 1'b1;
          a_d     = stk_r_data;
          state_d = (op_q == OP_DROP) ? S_IDLE : S_POP_B;
        end
      end

      // A lone operand is pushed back so an underflow leaves the stack as it was.
      S_POP_B: begin
        if (stk_empty) begin
          val_d     = a_q;
          restore_d = 1'b1;
          state_d   = S_PUSH;
        end else begin
          stk_rd  = 1'b1;
          b_d     = stk_r_data;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD:  val_d = b_q + a_q;
          OP_SUB:  val_d = b_q - a_q;
          OP_AND:  val_d = b_q & a_q;
          OP_OR:   val_d = b_q | a_q;
`ifdef RPN_MUL_EN
          OP_MUL:  val_d = b_q * a_q;
`endif
          default: val_d = val_q;
        endcase
        state_d = S_PUSH;
      end

      S_PUSH: begin
        if (stk_full) begin
          code_d  = CODE_OVF;
          state_d = S_ERR;
        end else begin
          stk_wr = 1'b1;
          res_d  = val_q;
          if (restore_q) begin
            restore_d = 1'b0;
            code_d    = CODE_UNF;
            state_d   = S_ERR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DUP_RD: begin
        if (stk_empty) begin
          code_d  = CODE_UNF;
          state_d = S_ERR;
        end else if (stk_full) begin
          code_d  = CODE_OVF;
          state_d = S_ERR;
        end else begin
          val_d   = stk_r_data;
          state_d = S_PUSH;
        end
      end

      S_ERR:   state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign stk_w_data = val_q;
  assign res_valid  = stk_wr;
  assign res_data   = stk_wr ? val_q : res_q;
  assign err        = (state_q == S_ERR);
  assign err_code   = code_q;

endmodule
